// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the MEM-stage load/store port with wait states,
// base-address translation and alignment/range checks. Define DMEM_BYTE_ENABLE_EN for per-byte store strobes.
module dmem_responder #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [3:0]            req_be_i,
`endif
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  busy_o
);

  localparam int         IDX_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam state_t ACC_STATE = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic                  accept;
  logic                  enter_resp;
  logic                  op_write;
  logic [31:0]           op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [31:0]           offset;
  logic [31:0]           index;
  logic                  op_error;
`ifdef DMEM_BYTE_ENABLE_EN
  logic [3:0]            lat_be;
  logic [3:0]            op_be;
`endif

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  assign req_ready_o = (state_q != ST_WAIT);
  assign accept      = req_valid_i & req_ready_o;
  assign enter_resp  = (state_d == ST_RESP);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign busy_o      = (state_q == ST_WAIT) || ((state_q == ST_RESP) && !accept);

  // With no wait states the response edge is also the acceptance edge, so decode the live request.
  always_comb begin
    if (WAIT_STATES == 0) begin
      op_write = req_write_i;
      op_addr  = req_addr_i;
      op_wdata = req_wdata_i;
    end else begin
      op_write = lat_write;
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
    end
`ifdef DMEM_BYTE_ENABLE_EN
    op_be = (WAIT_STATES == 0) ? req_be_i : lat_be;
`endif
  end

  assign offset   = op_addr - BASE_ADDR;
  assign index    = offset >> 2;
  assign op_error = (op_addr[1:0] != 2'b00) || (op_addr < BASE_ADDR) || (index >= MEMORY_DEPTH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ACC_STATE;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = accept ? ACC_STATE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
      lat_be    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= CNT_LOAD;
        lat_write <= req_write_i;
        lat_addr  <= req_addr_i;
        lat_wdata <= req_wdata_i;
`ifdef DMEM_BYTE_ENABLE_EN
        lat_be    <= req_be_i;
`endif
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (!op_write && !op_error) ? mem[index[IDX_W-1:0]] : '0;
        error_q <= op_error;
      end else begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  // Storage is never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && op_write && !op_error) begin
`ifdef DMEM_BYTE_ENABLE_EN
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem[index[IDX_W-1:0]][8*b +: 8] <= op_wdata[8*b +: 8];
      end
`else
      mem[index[IDX_W-1:0]] <= op_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at two wait states, one at zero wait states.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int          DW    = 32;
  localparam int          DEPTH = 256;
  localparam int          WS_A  = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = 4'hF;
  logic          a_valid = 1'b0;
  logic          z_valid = 1'b0;

  logic          a_ready, a_rsp_valid, a_rsp_error, a_busy;
  logic [DW-1:0] a_rdata;
  logic          z_ready, z_rsp_valid, z_rsp_error, z_busy;
  logic [DW-1:0] z_rdata;

  int            cycle = 0;
  int            checks = 0;
  int            failures = 0;
  exp_t          a_q[$];
  exp_t          z_q[$];
  exp_t          a_e, z_e;
  logic [31:0]   a_mem[int];
  logic [31:0]   z_mem[int];

  dmem_responder #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS_A), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid_i(a_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be_i(req_be),
`endif
    .req_ready_o(a_ready), .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata),
    .rsp_error_o(a_rsp_error), .busy_o(a_busy)
  );

  dmem_responder #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid_i(z_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be_i(req_be),
`endif
    .req_ready_o(z_ready), .rsp_valid_o(z_rsp_valid), .rsp_rdata_o(z_rdata),
    .rsp_error_o(z_rsp_error), .busy_o(z_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // Drives one request, waits (bounded) for acceptance, predicts the response and leaves valid high.
  task automatic applyStimulus(input bit z, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic [31:0] off, idx, word;
    bit          err;
    int          n;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (z) z_valid = 1'b1; else a_valid = 1'b1;
    n = 0;
    while (((z ? z_ready : a_ready) !== 1'b1) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      a_valid = 1'b0;
      z_valid = 1'b0;
      return;
    end
    off     = addr - BASE;
    idx     = off >> 2;
    err     = (addr[1:0] != 2'b00) || (addr < BASE) || (idx >= DEPTH);
    e.err   = err;
    e.rdata = '0;
    e.due   = cycle + (z ? 0 : WS_A) + 1;
    if (!err) begin
      if (wr) begin
`ifdef DMEM_BYTE_ENABLE_EN
        word = z ? z_mem[int'(idx)] : a_mem[int'(idx)];
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
`else
        word = wdata;
`endif
        if (z) z_mem[int'(idx)] = word; else a_mem[int'(idx)] = word;
      end else begin
        e.rdata = z ? z_mem[int'(idx)] : a_mem[int'(idx)];
      end
    end
    if (z) z_q.push_back(e); else a_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    a_valid = 1'b0;
    z_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && a_rsp_valid) begin
      if (a_q.size() == 0) checkOutput("a_unexpected_rsp", 32'd1, 32'd0);
      else begin
        a_e = a_q.pop_front();
        checkOutput("a_rdata", a_rdata, a_e.rdata);
        checkOutput("a_error", {31'd0, a_rsp_error}, {31'd0, a_e.err});
        checkOutput("a_latency", cycle, a_e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && z_rsp_valid) begin
      if (z_q.size() == 0) checkOutput("z_unexpected_rsp", 32'd1, 32'd0);
      else begin
        z_e = z_q.pop_front();
        checkOutput("z_rdata", z_rdata, z_e.rdata);
        checkOutput("z_error", {31'd0, z_rsp_error}, {31'd0, z_e.err});
        checkOutput("z_latency", cycle, z_e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    int          seen;
    int          n;
    #12;
    checkOutput("reset_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    checkOutput("reset_rdata", a_rdata, 32'd0);
    checkOutput("reset_error", {31'd0, a_rsp_error}, 32'd0);
    checkOutput("reset_busy", {31'd0, a_busy}, 32'd0);
    checkOutput("reset_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    a_valid = 1'b0;
    checkOutput("ready_in_wait", {31'd0, a_ready}, 32'd0);
    checkOutput("busy_in_wait", {31'd0, a_busy}, 32'd1);
    repeat (4) @(negedge clk);
    applyStimulus(0, 0, 32'h1001_0008, 32'h0, 4'hF);
    idleCycles(4);

    applyStimulus(0, 0, 32'h1001_0002, 32'h0, 4'hF);
    idleCycles(4);
    applyStimulus(0, 1, 32'h1001_03FC, 32'h55AA_55AA, 4'hF);
    idleCycles(4);
    applyStimulus(0, 1, 32'h1001_0400, 32'hFFFF_FFFF, 4'hF);
    idleCycles(4);
    applyStimulus(0, 0, 32'h1001_03FC, 32'h0, 4'hF);
    applyStimulus(0, 0, 32'h1000_FFFC, 32'h0, 4'hF);
    idleCycles(4);

    applyStimulus(0, 1, 32'h1001_000C, 32'h0123_4567, 4'hF);
    applyStimulus(0, 0, 32'h1001_0008, 32'h0, 4'hF);
    applyStimulus(0, 0, 32'h1001_000C, 32'h0, 4'hF);
    applyStimulus(0, 0, 32'h1001_03FC, 32'h0, 4'hF);
    idleCycles(5);

    applyStimulus(0, 1, 32'h1001_0000, 32'h0BAD_F00D, 4'hF);
    idleCycles(4);
    saved = a_mem[0];
    applyStimulus(0, 1, 32'h1001_0000, 32'h1234_5678, 4'hF);
    @(negedge clk);
    a_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    checkOutput("midreset_busy", {31'd0, a_busy}, 32'd0);
    a_q.delete();
    a_mem[0] = saved;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("ready_after_reset", {31'd0, a_ready}, 32'd1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_rsp_valid) seen++;
    end
    checkOutput("no_rsp_after_reset", seen, 32'd0);
    applyStimulus(0, 0, 32'h1001_0000, 32'h0, 4'hF);
    idleCycles(4);

`ifdef DMEM_BYTE_ENABLE_EN
    applyStimulus(0, 1, 32'h1001_0010, 32'hAABB_CCDD, 4'hF);
    idleCycles(4);
    applyStimulus(0, 1, 32'h1001_0010, 32'h1122_3344, 4'b0011);
    idleCycles(4);
    applyStimulus(0, 0, 32'h1001_0010, 32'h0, 4'b0000);
    idleCycles(4);
    checkOutput("be_merge_model", a_mem[4], 32'hAABB_3344);
    applyStimulus(0, 1, 32'h1001_0010, 32'hFFFF_FFFF, 4'b0000);
    idleCycles(4);
    applyStimulus(0, 0, 32'h1001_0010, 32'h0, 4'b0100);
    idleCycles(4);
`endif

    applyStimulus(1, 1, 32'h1001_0004, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1, 0, 32'h1001_0004, 32'h0, 4'hF);
    applyStimulus(1, 0, 32'h1001_0005, 32'h0, 4'hF);
    applyStimulus(1, 1, 32'h1001_0800, 32'h7777_7777, 4'hF);
    idleCycles(3);

    n = 0;
    while (((a_q.size() + z_q.size()) != 0) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queue_drained", a_q.size() + z_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the MEM-stage load/store interface.
- Accepts one load or store request at a time from the processor's MEM stage and performs base-address translation, alignment checks and range checks.
- Inserts a configurable number of wait states, then returns a one-cycle response pulse.
- Replaces the zero-latency data RAM so the pipeline can be exercised against realistic memory latency; the MEM stage stalls on req_ready_o/rsp_valid_o.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- MEMORY_DEPTH, 256, number of words in the storage array.
- WAIT_STATES, 2, cycles spent in WAIT before the response; legal range 0..15.
- BASE_ADDR, 32'h1001_0000, byte address of word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  DATA_WIDTH  store data.
- req_ready_o  output  1  responder can accept a request this cycle.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_rdata_o  output  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_error_o  output  1  request was misaligned or out of range; qualified by rsp_valid_o.
- busy_o  output  1  state is WAIT, or RESP with no new acceptance.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, wait counter = 0, latched request cleared.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_error_o = 0, busy_o = 0.
  - Storage array is NOT cleared.
- States: IDLE, WAIT, RESP.
- req_ready_o = 1 in IDLE and in RESP; 0 in WAIT.
- Acceptance occurs when req_valid_i & req_ready_o are both high at a rising edge. On acceptance:
  - latch write flag, address and wdata;
  - load counter = WAIT_STATES - 1;
  - next state = WAIT if WAIT_STATES > 0, else RESP.
- WAIT: counter decrements each cycle; when counter = 0, next state = RESP.
- Address decode, on the latched address:
  - offset = addr - BASE_ADDR (32-bit unsigned);
  - index = offset >> 2;
  - error = (addr[1:0] != 0) | (addr < BASE_ADDR) | (index >= MEMORY_DEPTH).
- On the edge entering RESP:
  - store without error: mem[index] <= wdata;
  - load without error: rsp_rdata_o <= mem[index];
  - otherwise rsp_rdata_o <= 0, and a store with error leaves memory unmodified;
  - rsp_error_o <= error.
- RESP lasts exactly one cycle with rsp_valid_o = 1. There is no response backpressure.
  - New request accepted in RESP: next state = WAIT, or RESP if WAIT_STATES = 0.
  - Otherwise: next state = IDLE, and rsp_valid_o, rsp_rdata_o and rsp_error_o return to 0.
- Latency: request accepted in cycle T gives rsp_valid_o in cycle T + WAIT_STATES + 1.
  - Peak throughput is one request per WAIT_STATES + 1 cycles.
- req_* inputs are ignored when not accepted; changing them during WAIT has no effect.
- Reset mid-WAIT: pending store discarded, no response issued; responder returns to IDLE.
- Counter is 4 bits; WAIT_STATES > 15 is a configuration error.

Optional Feature:
- Macro DMEM_BYTE_ENABLE_EN.
- Defined:
  - adds port req_be_i, input, 4, per-byte store strobes, latched with the request;
  - a store writes only the bytes whose strobe is set (bit 0 = bits 7:0);
  - be = 0 is a legal no-op store with a normal response;
  - loads ignore req_be_i and return the full word.
- Undefined: port absent; stores always write the full word.

Test Plan:
- Writes and reads at WAIT_STATES = 2:
  - store 0xDEADBEEF to 0x1001_0008 accepted in cycle T -> rsp_valid_o = 1 in T+3 only, rsp_error_o = 0, rsp_rdata_o = 0;
  - load 0x1001_0008 -> rsp_rdata_o = 0xDEADBEEF three cycles after acceptance.
- Error handling:
  - load 0x1001_0002 -> rsp_error_o = 1, rsp_rdata_o = 0;
  - store 0xFFFF_FFFF to 0x1001_0400 (index 256) -> rsp_error_o = 1, and a following load of 0x1001_03FC returns its prior value unchanged.
- Back-to-back:
  - req_valid_i held high with new loads -> second request accepted in the RESP cycle of the first;
  - responses arrive every 3 cycles; req_ready_o = 0 during WAIT.
- Reset mid-operation:
  - reset pulsed low during WAIT of a store of 0x12345678 to 0x1001_0000 -> no rsp_valid_o;
  - req_ready_o = 1 after release;
  - a load of 0x1001_0000 returns its pre-store value.
- Zero-wait and byte enables:
  - WAIT_STATES = 0 -> rsp_valid_o in T+1;
  - with DMEM_BYTE_ENABLE_EN, word 0xAABBCCDD, store 0x11223344 with be = 4'b0011 -> subsequent load returns 0xAABB3344.
